// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and helpers for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Replicated to any data width as {DATA_WIDTH{ZERO_BIT}}
    localparam logic ZERO_BIT = 1'b0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// rtl/regfile_init_seq.sv - post-reset clear sequencer: walks every entry once, then reports ready
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int AW      = clog2(REG_NUM)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output logic          init_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(REG_NUM - 1);

    state_e        state;
    state_e        state_next;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_next;

    // State and clear-counter registers; reset restarts the walk from entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: clear one entry per cycle, leave CLEAR after the last entry
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_en     = 1'b0;
        init_done  = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_READY: begin
                init_done = 1'b1;
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass, zero entry and clear sequence
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1,
    parameter int AW         = clog2(REG_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    input  logic [NUM_WR*AW-1:0]         wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_WR-1:0]            wr_en,
    output logic                         init_done
);

    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{ZERO_BIT}};

    logic                  clr_en;
    logic [AW-1:0]         clr_addr;
    logic                  user_en;
    logic [DATA_WIDTH-1:0] mem     [REG_NUM];
    logic                  wr_hit  [REG_NUM];
    logic [DATA_WIDTH-1:0] wr_val  [REG_NUM];
    logic [DATA_WIDTH-1:0] rd_next [NUM_RD];
    logic [NUM_RD*DATA_WIDTH-1:0] rd_q;

    regfile_init_seq #(
        .REG_NUM (REG_NUM),
        .AW      (AW)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    // User writes only land once the file is ready and not being reset
    assign user_en = init_done & ~rst;

    // Per-entry write resolve: later (higher-index) ports overwrite earlier ones,
    // so wr_val carries the collision winner; entry 0 is skipped when hardwired
    always_comb begin
        for (int e = 0; e < REG_NUM; e++) begin
            wr_hit[e] = 1'b0;
            wr_val[e] = ZERO_DATA;
            for (int j = 0; j < NUM_WR; j++) begin
                if (user_en && wr_en[j] && (wr_addr[j*AW +: AW] == AW'(e)) &&
                    !((ZERO_REG != 0) && (e == 0))) begin
                    wr_hit[e] = 1'b1;
                    wr_val[e] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Storage update: the clear sequencer owns the array until ready
    always_ff @(posedge clk) begin
        for (int e = 0; e < REG_NUM; e++) begin
            if (clr_en && (clr_addr == AW'(e))) begin
                mem[e] <= ZERO_DATA;
            end else if (wr_hit[e]) begin
                mem[e] <= wr_val[e];
            end
        end
    end

    // Per-port read mux; out-of-range addresses match no entry and read 0.
    // Bypass reuses the resolved write so it never fires for entry 0 or out of range.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_next[i] = ZERO_DATA;
            for (int e = 0; e < REG_NUM; e++) begin
                if (rd_addr[i*AW +: AW] == AW'(e)) begin
                    rd_next[i] = mem[e];
                    if ((BYPASS != 0) && wr_hit[e]) begin
                        rd_next[i] = wr_val[e];
                    end
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)) begin
                rd_next[i] = ZERO_DATA;
            end
        end
    end

    // Registered read data, forced to zero during reset and clearing
    always_ff @(posedge clk) begin
        if (rst || !init_done) begin
            rd_q <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_q[i*DATA_WIDTH +: DATA_WIDTH] <= rd_next[i];
            end
        end
    end

    assign rd_data = rd_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp in three configurations
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  rd_addr;
    logic [5:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_en;
    logic [63:0] rd_a, rd_b, rd_c;
    logic        done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: REG_NUM=8 with bypass
    regfile_mp #(
        .DATA_WIDTH (32), .REG_NUM (8), .NUM_RD (2), .NUM_WR (2), .BYPASS (1), .ZERO_REG (1)
    ) u_a (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_a),
        .wr_addr (wr_addr), .wr_data (wr_data), .wr_en (wr_en), .init_done (done_a)
    );

    // B: REG_NUM=8 without bypass
    regfile_mp #(
        .DATA_WIDTH (32), .REG_NUM (8), .NUM_RD (2), .NUM_WR (2), .BYPASS (0), .ZERO_REG (1)
    ) u_b (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_b),
        .wr_addr (wr_addr), .wr_data (wr_data), .wr_en (wr_en), .init_done (done_b)
    );

    // C: REG_NUM=6, addresses 6 and 7 out of range
    regfile_mp #(
        .DATA_WIDTH (32), .REG_NUM (6), .NUM_RD (2), .NUM_WR (2), .BYPASS (1), .ZERO_REG (1)
    ) u_c (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_c),
        .wr_addr (wr_addr), .wr_data (wr_data), .wr_en (wr_en), .init_done (done_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [2:0] a0, input logic [31:0] d0,
                          input logic [2:0] a1, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    task automatic set_rd(input logic [2:0] p0, input logic [2:0] p1);
        rd_addr = {p1, p0};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_rd(3'd0, 3'd0);
        set_wr(2'b11, 3'd1, 32'h55, 3'd2, 32'h66);

        // Reset state
        step();
        step();
        chk("rst_done_a", {31'b0, done_a}, 32'd0);
        chk("rst_done_c", {31'b0, done_c}, 32'd0);
        chk("rst_rd_a0", rd_a[31:0], 32'd0);
        chk("rst_rd_a1", rd_a[63:32], 32'd0);

        // Clear sequence with writes held on
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("clr_done_a_%0d", k), {31'b0, done_a}, (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("clr_done_c_%0d", k), {31'b0, done_c}, (k >= 6) ? 32'd1 : 32'd0);
        end
        set_wr(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);

        // Every entry cleared, held writes discarded
        for (int e = 0; e < 8; e += 2) begin
            set_rd(3'(e), 3'(e + 1));
            step();
            chk($sformatf("clr_a_%0d", e), rd_a[31:0], 32'd0);
            chk($sformatf("clr_a_%0d", e + 1), rd_a[63:32], 32'd0);
            chk($sformatf("clr_b_%0d", e + 1), rd_b[63:32], 32'd0);
        end

        // Basic write then read on the other port
        set_rd(3'd0, 3'd0);
        set_wr(2'b01, 3'd3, 32'hDEADBEEF, 3'd0, 32'd0);
        step();
        set_wr(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        set_rd(3'd0, 3'd3);
        step();
        chk("basic_a", rd_a[63:32], 32'hDEADBEEF);

        // Collision on addr 5 with same-cycle read
        set_wr(2'b11, 3'd5, 32'h1111, 3'd5, 32'h2222);
        set_rd(3'd5, 3'd0);
        step();
        chk("coll_byp_a", rd_a[31:0], 32'h2222);
        chk("coll_nobyp_b", rd_b[31:0], 32'h0);
        set_wr(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        step();
        chk("coll_later_a", rd_a[31:0], 32'h2222);
        chk("coll_later_b", rd_b[31:0], 32'h2222);

        // Read-during-write without bypass
        set_wr(2'b01, 3'd2, 32'hA, 3'd0, 32'd0);
        step();
        set_wr(2'b01, 3'd2, 32'hB, 3'd0, 32'd0);
        set_rd(3'd2, 3'd0);
        step();
        chk("rdw_old_b", rd_b[31:0], 32'hA);
        chk("rdw_byp_a", rd_a[31:0], 32'hB);
        set_wr(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        step();
        chk("rdw_new_b", rd_b[31:0], 32'hB);

        // Zero entry and out-of-range on the 6-entry file
        set_wr(2'b11, 3'd1, 32'h101, 3'd2, 32'h102);
        step();
        set_wr(2'b11, 3'd3, 32'h103, 3'd4, 32'h104);
        step();
        set_wr(2'b01, 3'd5, 32'h105, 3'd0, 32'd0);
        step();
        set_wr(2'b11, 3'd7, 32'hFFFF, 3'd0, 32'hFFFF);
        set_rd(3'd0, 3'd7);
        step();
        chk("zr_byp_c0", rd_c[31:0], 32'd0);
        chk("oor_byp_c7", rd_c[63:32], 32'd0);
        chk("zr_byp_a0", rd_a[31:0], 32'd0);
        chk("inr_byp_a7", rd_a[63:32], 32'hFFFF);
        set_wr(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        step();
        chk("zr_c0", rd_c[31:0], 32'd0);
        chk("oor_c7", rd_c[63:32], 32'd0);
        for (int e = 1; e < 7; e += 2) begin
            set_rd(3'(e), 3'(e + 1));
            step();
            chk($sformatf("keep_c_%0d", e), rd_c[31:0], 32'h100 + 32'(e));
            chk($sformatf("keep_c_%0d", e + 1), rd_c[63:32], (e + 1 < 6) ? 32'h100 + 32'(e + 1) : 32'd0);
        end

        // Reset from READY, then again mid-clear
        set_rd(3'd5, 3'd7);
        set_wr(2'b11, 3'd3, 32'hCAFE, 3'd4, 32'hBEEF);
        rst = 1'b1;
        step();
        chk("rst_drop_a", {31'b0, done_a}, 32'd0);
        rst = 1'b0;
        step();
        step();
        step();
        chk("mid_clr_done_a", {31'b0, done_a}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("reclr_done_a_%0d", k), {31'b0, done_a}, (k == 8) ? 32'd1 : 32'd0);
            if (k == 1) begin
                chk("reclr_rd_a5", rd_a[31:0], 32'd0);
                chk("reclr_rd_a7", rd_a[63:32], 32'd0);
            end
        end
        set_wr(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        set_rd(3'd3, 3'd4);
        step();
        chk("reclr_nowr_a3", rd_a[31:0], 32'd0);
        chk("reclr_nowr_a4", rd_a[63:32], 32'd0);
        chk("reclr_nowr_b3", rd_b[31:0], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
